// File: rtl/scb_arbiter_if.sv
// -----------------------------------------------------------------------------
// scb_arbiter_if
// Bundles the two request ports and the scratchpad (SCB) port of scb_arbiter.
// Signal suffixes (_i/_o) are named from the arbiter's point of view.
//
//   p0_* / p1_* : single-word request/ack handshake per master
//                 (req, we, addr, wdata, be in; ack, rdata out)
//   scb_*       : scratchpad port (Addr, Data, stb, ce, rd, active-low wr out;
//                 Data_i, rdy_i in)
//
// Modports:
//   slave  - used by scb_arbiter (serves the masters, drives the scratchpad)
//   master - used by the environment (masters plus scratchpad)
// -----------------------------------------------------------------------------
interface scb_arbiter_if #(
  parameter int A = 11,
  parameter int D = 16,
  parameter int B = 2
) ();

  // Port 0 (core load/store)
  logic         p0_req_i;
  logic         p0_we_i;
  logic [A-1:0] p0_addr_i;
  logic [D-1:0] p0_wdata_i;
  logic [B-1:0] p0_be_i;
  logic         p0_ack_o;
  logic [D-1:0] p0_rdata_o;

  // Port 1 (host bridge)
  logic         p1_req_i;
  logic         p1_we_i;
  logic [A-1:0] p1_addr_i;
  logic [D-1:0] p1_wdata_i;
  logic [B-1:0] p1_be_i;
  logic         p1_ack_o;
  logic [D-1:0] p1_rdata_o;

  // Scratchpad port
  logic [A-1:0] scb_Addr_o;
  logic [D-1:0] scb_Data_o;
  logic [D-1:0] scb_Data_i;
  logic [B-1:0] scb_stb_o;
  logic         scb_ce_o;
  logic         scb_rd_o;
  logic         scb_wr_o;
  logic         scb_rdy_i;

  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i, p0_be_i,
    output p0_ack_o, p0_rdata_o,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_be_i,
    output p1_ack_o, p1_rdata_o,
    output scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o,
    input  scb_Data_i, scb_rdy_i
  );

  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i, p0_be_i,
    input  p0_ack_o, p0_rdata_o,
    output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_be_i,
    input  p1_ack_o, p1_rdata_o,
    input  scb_Addr_o, scb_Data_o, scb_stb_o, scb_ce_o, scb_rd_o, scb_wr_o,
    output scb_Data_i, scb_rdy_i
  );

endinterface : scb_arbiter_if

// File: rtl/scb_arbiter.sv
// -----------------------------------------------------------------------------
// scb_arbiter
// Two-port round-robin arbiter and sequencer in front of the 2 KB scratchpad.
// One single-word access is in flight at a time:
//   write: IDLE -> ISSUE -> ACK -> IDLE
//   read : IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE
// ISSUE is extended while scb_rdy_i is low.
//
// Ports:
//   clk_i - clock, all state changes on the rising edge
//   rst_i - synchronous active-high reset (aborts any access in flight)
//   bus   - scb_arbiter_if.slave: both master ports and the scratchpad port
//
// The winner's request is registered on entry to ISSUE; every scb_* output is
// decoded from the state and those registers only, never from pN_* inputs.
// -----------------------------------------------------------------------------
module scb_arbiter #(
  parameter int A = 11,  // byte address width (bit 10 = bank, 9:1 = word)
  parameter int D = 16,  // data width
  parameter int B = 2    // byte strobes
) (
  input  logic         clk_i,
  input  logic         rst_i,
  scb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_e;

  state_e       state_q,      state_d;
  logic         last_grant_q, last_grant_d;  // 1 = port 1 was granted last
  logic         grant_q,      grant_d;       // port owning the current access
  logic         we_q,         we_d;
  logic [A-1:0] addr_q,       addr_d;
  logic [D-1:0] wdata_q,      wdata_d;
  logic [B-1:0] be_q,         be_d;
  logic [D-1:0] rdata0_q,     rdata0_d;
  logic [D-1:0] rdata1_q,     rdata1_d;

  logic         any_req;
  logic         pick_p1;
  logic         ce;
  logic         rd;
  logic         wr_n;
  logic [B-1:0] stb;
  logic         ack0;
  logic         ack1;

  assign any_req = bus.p0_req_i | bus.p1_req_i;

  // Port 1 wins when it is the only requester, or when both request and
  // port 0 was the last one served.
  assign pick_p1 = bus.p1_req_i & (~bus.p0_req_i | ~last_grant_q);

  // Next-state and output decode.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ce           = 1'b0;
    rd           = 1'b0;
    wr_n         = 1'b1;
    stb          = '0;
    ack0         = 1'b0;
    ack1         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d      = pick_p1;
          last_grant_d = pick_p1;
          we_d         = pick_p1 ? bus.p1_we_i    : bus.p0_we_i;
          addr_d       = pick_p1 ? bus.p1_addr_i  : bus.p0_addr_i;
          wdata_d      = pick_p1 ? bus.p1_wdata_i : bus.p0_wdata_i;
          be_d         = pick_p1 ? bus.p1_be_i    : bus.p0_be_i;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        ce   = 1'b1;
        stb  = be_q;
        wr_n = ~we_q;
        rd   = ~we_q;
        if (bus.scb_rdy_i) begin
          state_d = we_q ? ST_ACK : ST_CAPTURE;
        end
      end

      // No strobe is active, but ce and the held address keep the
      // scratchpad's bank output mux on the bank that was just read.
      ST_CAPTURE: begin
        ce = 1'b1;
        rd = 1'b1;
        if (grant_q) begin
          rdata1_d = bus.scb_Data_i;
        end else begin
          rdata0_d = bus.scb_Data_i;
        end
        state_d = ST_ACK;
      end

      // Outputs as in IDLE; requests are not sampled here.
      ST_ACK: begin
        ack0    = ~grant_q;
        ack1    = grant_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.scb_Addr_o = addr_q;
  assign bus.scb_Data_o = wdata_q;
  assign bus.scb_stb_o  = stb;
  assign bus.scb_ce_o   = ce;
  assign bus.scb_rd_o   = rd;
  assign bus.scb_wr_o   = wr_n;
  assign bus.p0_ack_o   = ack0;
  assign bus.p1_ack_o   = ack1;
  assign bus.p0_rdata_o = rdata0_q;
  assign bus.p1_rdata_o = rdata1_q;

endmodule : scb_arbiter

// File: tb/tb_scb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_scb_arbiter
// Bench for scb_arbiter with a behavioural scratchpad behind the SCB port and
// a transaction-level reference model compared against the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_scb_arbiter;

  localparam int A = 11;
  localparam int D = 16;
  localparam int B = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  scb_arbiter_if #(.A(A), .D(D), .B(B)) bus ();

  scb_arbiter #(.A(A), .D(D), .B(B)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scratchpad: two banks of byte-wide macros with registered per-lane outputs,
  // and a bank mux selected by the current address.
  // ---------------------------------------------------------------------------
  logic [7:0] spm [0:2047];
  logic [7:0] spm_out [0:1][0:1];

  initial begin
    for (int i = 0; i < 2048; i++) spm[i] = 8'h00;
    for (int b = 0; b < 2; b++) begin
      spm_out[b][0] = 8'h00;
      spm_out[b][1] = 8'h00;
    end
  end

  always @(posedge clk_i) begin
    if (bus.scb_ce_o) begin
      for (int l = 0; l < 2; l++) begin
        if (bus.scb_stb_o[l]) begin
          if (!bus.scb_wr_o)
            spm[{bus.scb_Addr_o[10:1], l[0]}] <= bus.scb_Data_o[8*l +: 8];
          if (bus.scb_rd_o)
            spm_out[bus.scb_Addr_o[10]][l] <= spm[{bus.scb_Addr_o[10:1], l[0]}];
        end
      end
    end
  end

  assign bus.scb_Data_i = {spm_out[bus.scb_Addr_o[10]][1], spm_out[bus.scb_Addr_o[10]][0]};

  // ---------------------------------------------------------------------------
  // Reference model: tracks one access by the number of cycles elapsed since
  // the scratchpad accepted it (m_after = 0 while still waiting on rdy).
  // ---------------------------------------------------------------------------
  bit          m_on = 0;
  bit          m_busy = 0;
  bit          m_port = 0;
  bit          m_we = 0;
  bit          m_last = 1;
  int          m_after = 0;
  logic [10:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [1:0]  m_be = '0;
  logic [15:0] m_mem [0:1023];
  logic [15:0] exp_rd0 = '0;
  logic [15:0] exp_rd1 = '0;
  int          ack_port_q[$];
  int          ack_cyc_q[$];
  logic [10:0] iss_addr = '0;
  logic [10:0] cap_addr = '0;

  initial for (int i = 0; i < 1024; i++) m_mem[i] = 16'h0000;

  always @(negedge clk_i) begin
    logic       e_ce, e_rd, e_wr, e_a0, e_a1;
    logic [1:0] e_stb;
    if (m_on) begin
      e_ce = 1'b0; e_rd = 1'b0; e_wr = 1'b1; e_stb = 2'b00; e_a0 = 1'b0; e_a1 = 1'b0;
      if (m_busy) begin
        if (m_after == 0) begin
          e_ce = 1'b1; e_stb = m_be; e_wr = ~m_we; e_rd = ~m_we;
          check("issue_addr", 32'(bus.scb_Addr_o), 32'(m_addr));
          if (m_we) check("issue_wdata", 32'(bus.scb_Data_o), 32'(m_wdata));
        end else if (!m_we && m_after == 1) begin
          e_ce = 1'b1; e_rd = 1'b1;
          check("capture_addr", 32'(bus.scb_Addr_o), 32'(m_addr));
        end else begin
          e_a0 = ~m_port; e_a1 = m_port;
        end
      end
      check("scb_ce", 32'(bus.scb_ce_o), 32'(e_ce));
      check("scb_rd", 32'(bus.scb_rd_o), 32'(e_rd));
      check("scb_wr", 32'(bus.scb_wr_o), 32'(e_wr));
      check("scb_stb", 32'(bus.scb_stb_o), 32'(e_stb));
      check("p0_ack", 32'(bus.p0_ack_o), 32'(e_a0));
      check("p1_ack", 32'(bus.p1_ack_o), 32'(e_a1));
      check("p0_rdata", 32'(bus.p0_rdata_o), 32'(exp_rd0));
      check("p1_rdata", 32'(bus.p1_rdata_o), 32'(exp_rd1));
    end
    if (bus.p0_ack_o || bus.p1_ack_o) begin
      ack_port_q.push_back(bus.p1_ack_o ? 1 : 0);
      ack_cyc_q.push_back(cyc);
    end
    if (bus.scb_ce_o && bus.scb_stb_o != 2'b00) iss_addr = bus.scb_Addr_o;
    if (bus.scb_ce_o && bus.scb_stb_o == 2'b00) cap_addr = bus.scb_Addr_o;

    // advance the model using this cycle's inputs
    if (rst_i) begin
      m_on = 1; m_busy = 0; m_last = 1; exp_rd0 = '0; exp_rd1 = '0;
    end else if (m_on) begin
      if (!m_busy) begin
        if (bus.p0_req_i || bus.p1_req_i) begin
          m_port  = (bus.p0_req_i && bus.p1_req_i) ? !m_last : bus.p1_req_i;
          m_last  = m_port;
          m_we    = m_port ? bus.p1_we_i    : bus.p0_we_i;
          m_addr  = m_port ? bus.p1_addr_i  : bus.p0_addr_i;
          m_wdata = m_port ? bus.p1_wdata_i : bus.p0_wdata_i;
          m_be    = m_port ? bus.p1_be_i    : bus.p0_be_i;
          m_busy  = 1; m_after = 0;
        end
      end else if (m_after == 0) begin
        if (bus.scb_rdy_i) begin
          m_after = 1;
          if (m_we) begin
            if (m_be[0]) m_mem[m_addr[10:1]][7:0]  = m_wdata[7:0];
            if (m_be[1]) m_mem[m_addr[10:1]][15:8] = m_wdata[15:8];
          end
        end
      end else if (m_after == (m_we ? 1 : 2)) begin
        m_busy = 0;
      end else begin
        if (m_port) exp_rd1 = m_mem[m_addr[10:1]];
        else        exp_rd0 = m_mem[m_addr[10:1]];
        m_after = m_after + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 1 ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic drive_req(input int port, input logic req, input logic we,
                           input logic [10:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be);
    if (port == 0) begin
      bus.p0_req_i = req; bus.p0_we_i = we; bus.p0_addr_i = addr;
      bus.p0_wdata_i = wdata; bus.p0_be_i = be;
    end else begin
      bus.p1_req_i = req; bus.p1_we_i = we; bus.p1_addr_i = addr;
      bus.p1_wdata_i = wdata; bus.p1_be_i = be;
    end
  endtask

  // One access; lat is the ack cycle counted from the request cycle.
  // stall = number of ISSUE cycles with scb_rdy_i low; keep = leave req high.
  task automatic access(input int port, input logic we, input logic [10:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input int stall, input bit keep,
                        output logic [15:0] rdata, output int lat);
    int start;
    bit got;
    drive_req(port, 1'b1, we, addr, wdata, be);
    if (stall > 0) bus.scb_rdy_i = 1'b0;
    start = cyc; got = 0; rdata = '0; lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if ((port == 0) ? bus.p0_ack_o : bus.p1_ack_o) begin
        got   = 1;
        lat   = cyc - start;
        rdata = (port == 0) ? bus.p0_rdata_o : bus.p1_rdata_o;
      end
      @(posedge clk_i); #1;
      if (i >= stall) bus.scb_rdy_i = 1'b1;
    end
    check("ack_seen", 32'(got), 32'd1);
    if (!keep) drive_req(port, 1'b0, we, addr, wdata, be);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] v;
    int          l;

    rst_i = 1'b1;
    bus.scb_rdy_i = 1'b1;
    drive_req(0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0, '0);

    // reset held for two rising edges
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_ce",    32'(bus.scb_ce_o),   32'd0);
    check("rst_stb",   32'(bus.scb_stb_o),  32'd0);
    check("rst_rd",    32'(bus.scb_rd_o),   32'd0);
    check("rst_wr",    32'(bus.scb_wr_o),   32'd1);
    check("rst_addr",  32'(bus.scb_Addr_o), 32'd0);
    check("rst_data",  32'(bus.scb_Data_o), 32'd0);
    check("rst_ack",   32'({bus.p1_ack_o, bus.p0_ack_o}), 32'd0);
    check("rst_rdata", 32'({bus.p1_rdata_o, bus.p0_rdata_o}), 32'd0);
    @(posedge clk_i); #1;

    // port 0 write then read back 0x402
    access(0, 1'b1, 11'h402, 16'hBEEF, 2'b11, 0, 0, v, l);
    check("wr_lat", 32'(l), 32'd2);
    access(0, 1'b0, 11'h402, 16'h0000, 2'b11, 0, 0, v, l);
    check("rd_lat", 32'(l), 32'd3);
    check("rd_beef", 32'(v), 32'hBEEF);
    check("rd_issue_addr", 32'(iss_addr), 32'h402);
    check("rd_cap_addr", 32'(cap_addr), 32'h402);

    // be=0 write is acked and leaves memory untouched
    access(0, 1'b1, 11'h402, 16'hFFFF, 2'b00, 0, 0, v, l);
    check("be0_lat", 32'(l), 32'd2);
    access(1, 1'b0, 11'h402, 16'h0000, 2'b11, 0, 0, v, l);
    check("be0_keep", 32'(v), 32'hBEEF);

    // byte lanes, low bank then high bank at the same word index
    access(0, 1'b1, 11'h010, 16'h1234, 2'b11, 0, 0, v, l);
    access(0, 1'b1, 11'h010, 16'hAB00, 2'b10, 0, 0, v, l);
    access(1, 1'b1, 11'h410, 16'h5678, 2'b11, 0, 0, v, l);
    access(1, 1'b1, 11'h410, 16'h00CD, 2'b01, 0, 0, v, l);
    access(0, 1'b0, 11'h010, 16'h0000, 2'b11, 0, 0, v, l);
    check("lane_lo", 32'(v), 32'hAB34);
    access(0, 1'b0, 11'h410, 16'h0000, 2'b11, 0, 0, v, l);
    check("lane_hi", 32'(v), 32'h56CD);

    // three wait states during a read ISSUE
    access(1, 1'b0, 11'h010, 16'h0000, 2'b11, 3, 0, v, l);
    check("ws_lat", 32'(l), 32'd6);
    check("ws_data", 32'(v), 32'hAB34);

    // reset asserted in CAPTURE aborts the read
    drive_req(0, 1'b1, 1'b0, 11'h402, 16'h0000, 2'b11);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_cap_ce", 32'(bus.scb_ce_o), 32'd1);
    check("abort_no_ack", 32'(bus.p0_ack_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive_req(0, 1'b0, 1'b0, 11'h402, 16'h0000, 2'b11);
    @(negedge clk_i);
    check("abort_idle_ce", 32'(bus.scb_ce_o), 32'd0);
    check("abort_idle_ack", 32'(bus.p0_ack_o), 32'd0);
    check("abort_rdata", 32'(bus.p0_rdata_o), 32'd0);
    @(posedge clk_i); #1;
    access(0, 1'b0, 11'h402, 16'h0000, 2'b11, 0, 0, v, l);
    check("reissue_lat", 32'(l), 32'd3);
    check("reissue_data", 32'(v), 32'hBEEF);

    // contention straight after reset: three back-to-back writes per port
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    ack_port_q.delete();
    ack_cyc_q.delete();
    fork
      begin : p0_seq
        logic [15:0] v0;
        int          l0;
        for (int r = 0; r < 3; r++)
          access(0, 1'b1, 11'(11'h100 + 2 * r), 16'(16'hC000 + r), 2'b11, 0, r < 2, v0, l0);
      end
      begin : p1_seq
        logic [15:0] v1;
        int          l1;
        for (int r = 0; r < 3; r++)
          access(1, 1'b1, 11'(11'h140 + 2 * r), 16'(16'hC100 + r), 2'b11, 0, r < 2, v1, l1);
      end
    join
    check("cont_count", 32'(ack_port_q.size()), 32'd6);
    for (int i = 0; i < ack_port_q.size() && i < 6; i++) begin
      check("cont_order", 32'(ack_port_q[i]), 32'(i % 2));
      if (i > 0) check("cont_gap", 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'd3);
    end
    access(1, 1'b0, 11'h144, 16'h0000, 2'b11, 0, 0, v, l);
    check("cont_rd_p1", 32'(v), 32'hC102);
    access(0, 1'b0, 11'h102, 16'h0000, 2'b11, 0, 0, v, l);
    check("cont_rd_p0", 32'(v), 32'hC001);

    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_scb_arbiter

// File: doc/scb_arbiter.md
# scb_arbiter

Two-port arbiter and sequencer for the 2 KB scratchpad (SCB memory). It accepts single-word requests from two masters: port 0 (Minx16 core load/store) and port 1 (Wishbone host bridge). It grants one at a time, round-robin. It drives the scratchpad's SCB port with the correct chip-enable, strobe and write-polarity sequencing, and returns registered read data. It sits directly upstream of the scratchpad and is its only driver.

## Interface
Parameters:
- A, 11: byte address width. Bit 10 selects the bank; bits 9:1 give the word index; bit 0 is ignored.
- D, 16: data width.
- B, 2: byte strobes. Bit 0 is the even byte D[7:0]; bit 1 is the odd byte D[15:8].

Ports. One clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous active-high reset
- pN_req_i  in  1  port N request (N = 0, 1); held high until pN_ack_o
- pN_we_i  in  1  1 = write, 0 = read
- pN_addr_i  in  A  byte address
- pN_wdata_i  in  D  write data
- pN_be_i  in  B  byte enables
- pN_ack_o  out  1  one-cycle completion pulse
- pN_rdata_o  out  D  read data, valid while pN_ack_o is high for a read
- scb_Addr_o  out  A  scratchpad address
- scb_Data_o  out  D  scratchpad write data
- scb_Data_i  in  D  scratchpad read data
- scb_stb_o  out  B  scratchpad byte strobes
- scb_ce_o  out  1  scratchpad chip enable
- scb_rd_o  out  1  read qualifier; high in every non-write active cycle
- scb_wr_o  out  1  active-low write. 0 = write this cycle (the scratchpad writes when ce=1 and wr=0); 1 otherwise
- scb_rdy_i  in  1  scratchpad ready; while 0, the ISSUE state holds

## Operation
- Request latch: the winner's we, addr, wdata and be are registered on entry to ISSUE. The scb_* outputs are driven only from these registers, never combinationally from pN_* inputs.
- Arbitration happens only in IDLE:
  - one requester: that port wins;
  - both requesting: the port not granted last time wins;
  - the last_grant register resets to 1, so port 0 wins the first contested cycle;
  - last_grant updates on every grant.
- States and transitions:
  - IDLE: scb_ce_o=0, scb_stb_o=0, scb_wr_o=1, scb_rd_o=0. Any request → ISSUE.
  - ISSUE: scb_ce_o=1, scb_stb_o=be, scb_Addr_o=addr.
    - Write: scb_wr_o=0, scb_rd_o=0, scb_Data_o=wdata.
    - Read: scb_wr_o=1, scb_rd_o=1.
    - If scb_rdy_i=0, stay in ISSUE with outputs unchanged.
    - Otherwise: write → ACK; read → CAPTURE.
  - CAPTURE (reads only): scb_ce_o=1, scb_stb_o=0, scb_rd_o=1, scb_wr_o=1, address held.
    - No macro is enabled, but ce and address keep the scratchpad's bank output mux pointing at the correct bank.
    - scb_Data_i is registered into the winner's rdata register. → ACK.
  - ACK: pN_ack_o=1 for the winner only; outputs as in IDLE. → IDLE.
- be=0 is legal: the access is sequenced normally with no byte enabled and is acked. For a be=0 read, rdata is whatever the macros last output.
- pN_rdata_o holds its last captured value between acks. It is updated only for reads.
- A port whose req is already low in IDLE is not granted. A request withdrawn before ack is illegal (undefined).

## Timing
- Cycle 0 is the first IDLE cycle that samples the request.
  - Write: ISSUE in cycle 1; ack in cycle 2; IDLE in cycle 3.
  - Read: ISSUE in cycle 1; CAPTURE in cycle 2; ack plus rdata in cycle 3; IDLE in cycle 4.
  - Each scb_rdy_i=0 cycle in ISSUE adds one cycle.
- Throughput: one write per 3 cycles, one read per 4. A master that drops req in the cycle after ack loses no cycles.
- Reset values:
  - state = IDLE;
  - all ack = 0;
  - rdata registers = 0;
  - scb_ce_o = 0, scb_stb_o = 0, scb_rd_o = 0, scb_wr_o = 1;
  - scb_Addr_o = 0, scb_Data_o = 0;
  - last_grant = 1.
- Reset asserted mid-access aborts the access: IDLE next cycle, no ack issued, and the master must reissue. A write already in ISSUE when reset is sampled may or may not have committed.
- Simultaneous requests in the ACK cycle are not sampled. They are arbitrated in the following IDLE cycle.

## Test plan
- Reset: hold rst_i for 2 cycles → all outputs at their reset values, scb_wr_o=1, no ack.
- Port 0 writes 0xBEEF to 0x402 with be=11, then reads it back → ack at cycle 2 and cycle 3 respectively; rdata=0xBEEF; scb_Addr_o=0x402 in both ISSUE and CAPTURE.
- Byte lanes: write 0x1234 to 0x010, then a be=10 write of 0xAB00 → read returns 0xAB34. Repeat at 0x410 (high bank) with independent data to confirm bank isolation.
- Contention: both ports request in the same cycle after reset, 3 rounds each → grants alternate P0, P1, P0, P1, P0, P1; acks are never simultaneous.
- Wait states: hold scb_rdy_i=0 for 3 cycles during a read ISSUE → outputs stable; read ack at cycle 6 with correct data.
- Reset mid-read asserted in CAPTURE → no ack; IDLE next cycle; a reissued read completes normally.
